// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
// Off levels for both segment polarities and a one-hot digit decoder.
package disp_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_OFF_HI = 7'h00;
    localparam logic [SEG_W-1:0] SEG_OFF_LO = 7'h7F;

    function automatic logic [NUM_DIGITS-1:0] onehot8(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler for the display scanner.
// Counts 0..CLK_DIV-1 while enabled and raises tick on the last count.
module scan_tick_gen #(
    parameter int CLK_DIV = 1000,
    parameter int CW      = $clog2(CLK_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tick
);

    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    assign tick = en && (cnt == LAST);

    // Advance the slot counter only while scanning; freeze it otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Eight-digit time-multiplexed 7-segment driver with per-frame snapshot.
// Shadow regs hold one coherent frame; outputs lag the scan state by one clk.
module seg_scan_mux
    import disp_pkg::*;
#(
    parameter int CLK_DIV        = 1000,
    parameter int BLANK_CYC      = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEG_W-1:0] seg_1,
    input  logic [SEG_W-1:0] seg_2,
    input  logic [SEG_W-1:0] seg_3,
    input  logic [SEG_W-1:0] seg_4,
    input  logic [SEG_W-1:0] seg_5,
    input  logic [SEG_W-1:0] seg_6,
    input  logic [SEG_W-1:0] seg_7,
    input  logic [SEG_W-1:0] seg_8,
    output logic [SEG_W-1:0] seg_out,
    output logic [7:0]       dig_sel,
    output logic             frame_start
);

    localparam int CW = $clog2(CLK_DIV);

    // Off level doubles as the inversion mask: raw off is all-zero.
    localparam logic [SEG_W-1:0] SEG_OFF =
        (SEG_ACTIVE_LOW != 0) ? SEG_OFF_LO : SEG_OFF_HI;
    localparam logic [7:0] DIG_OFF =
        (DIG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [CW-1:0]    cnt;
    logic             tick;
    logic [2:0]       idx;
    logic             load_pend;
    logic             capture;
    logic [SEG_W-1:0] seg_in [NUM_DIGITS];
    logic [SEG_W-1:0] shadow [NUM_DIGITS];
    logic [SEG_W-1:0] seg_raw;
    logic [7:0]       dig_raw;

    assign seg_in[0] = seg_1;
    assign seg_in[1] = seg_2;
    assign seg_in[2] = seg_3;
    assign seg_in[3] = seg_4;
    assign seg_in[4] = seg_5;
    assign seg_in[5] = seg_6;
    assign seg_in[6] = seg_7;
    assign seg_in[7] = seg_8;

    scan_tick_gen #(
        .CLK_DIV (CLK_DIV),
        .CW      (CW)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .cnt  (cnt),
        .tick (tick)
    );

    // A pending load and a frame wrap collapse into one capture.
    assign capture = en && (load_pend || (tick && idx == 3'd7));

    // Pulse is held low while reset is asserted.
    assign frame_start = capture && rst;

    // Step the digit index once per slot; hold while disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (tick) begin
            idx <= idx + 3'd1;
        end
    end

    // Snapshot all inputs at frame boundaries so a frame is never torn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_pend <= 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
            end
        end else if (capture) begin
            load_pend <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= seg_in[i];
            end
        end
    end

    // Select the current digit, blanking the strobe at slot start.
    always_comb begin
        seg_raw = shadow[idx];
        dig_raw = onehot8(idx);
        if (!en) begin
            seg_raw = '0;
            dig_raw = '0;
        end else if (int'(cnt) < BLANK_CYC) begin
            dig_raw = '0;
        end
    end

    // Register outputs with polarity applied on the way in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_out <= SEG_OFF;
            dig_sel <= DIG_OFF;
        end else begin
            seg_out <= seg_raw ^ SEG_OFF;
            dig_sel <= dig_raw ^ DIG_OFF;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: cycle scoreboard plus directed scenario checks.
// Runs an active-high and an active-low instance side by side.
module tb_seg_scan_mux;

    localparam int D = 4;
    localparam int B = 1;

    logic       clk;
    logic       rst;
    logic       en;
    logic [6:0] s [8];
    logic [6:0] p [8];
    logic [6:0] seg_out;
    logic [7:0] dig_sel;
    logic       fs;
    logic [6:0] seg_out1;
    logic [7:0] dig_sel1;
    logic       fs1;

    typedef struct packed {
        logic [6:0] seg;
        logic [7:0] dig;
        logic       off;
    } exp_t;

    exp_t       q [$];
    int         checks;
    int         errors;
    int         fs_cnt;
    int         m_cnt;
    int         m_idx;
    logic [6:0] m_sh [8];
    bit         m_pend;

    seg_scan_mux #(
        .CLK_DIV(D), .BLANK_CYC(B),
        .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) u0 (
        .clk(clk), .rst(rst), .en(en),
        .seg_1(s[0]), .seg_2(s[1]), .seg_3(s[2]), .seg_4(s[3]),
        .seg_5(s[4]), .seg_6(s[5]), .seg_7(s[6]), .seg_8(s[7]),
        .seg_out(seg_out), .dig_sel(dig_sel), .frame_start(fs)
    );

    seg_scan_mux #(
        .CLK_DIV(D), .BLANK_CYC(B),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) u1 (
        .clk(clk), .rst(rst), .en(en),
        .seg_1(p[0]), .seg_2(p[1]), .seg_3(p[2]), .seg_4(p[3]),
        .seg_5(p[4]), .seg_6(p[5]), .seg_7(p[6]), .seg_8(p[7]),
        .seg_out(seg_out1), .dig_sel(dig_sel1), .frame_start(fs1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_cnt  = 0;
        m_idx  = 0;
        m_pend = 1'b1;
        for (int i = 0; i < 8; i++) m_sh[i] = 7'h00;
        q.delete();
    endtask

    // One clock: check frame_start, push expectation, pop after the edge.
    task automatic cyc();
        bit   cap;
        exp_t e;
        @(negedge clk);
        cap = en && (m_pend || (m_cnt == D - 1 && m_idx == 7));
        checks++;
        if (fs !== cap) begin
            errors++;
            $display("FAIL frame_start got %0b exp %0b", fs, cap);
        end
        if (cap) fs_cnt++;
        e.off = !en;
        e.seg = en ? m_sh[m_idx] : 7'h00;
        e.dig = (!en || m_cnt < B) ? 8'h00 : (8'h01 << m_idx);
        q.push_back(e);
        if (cap) begin
            for (int i = 0; i < 8; i++) m_sh[i] = s[i];
            m_pend = 1'b0;
        end
        if (en) begin
            if (m_cnt == D - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 8;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if (seg_out !== e.seg || dig_sel !== e.dig) begin
            errors++;
            $display("FAIL scan got seg=%h dig=%h exp seg=%h dig=%h",
                     seg_out, dig_sel, e.seg, e.dig);
        end
        if (e.off) begin
            checks++;
            if (seg_out1 !== 7'h7F || dig_sel1 !== 8'hFF) begin
                errors++;
                $display("FAIL pol_off got seg=%h dig=%h exp 7f ff",
                         seg_out1, dig_sel1);
            end
        end else if (e.dig == 8'h01) begin
            checks++;
            if (seg_out1 !== 7'h7E || dig_sel1 !== 8'hFE) begin
                errors++;
                $display("FAIL pol_slot0 got seg=%h dig=%h exp 7e fe",
                         seg_out1, dig_sel1);
            end
        end
    endtask

    // Assert reset away from an edge, check it acts at once, release it.
    task automatic apply_reset();
        rst = 1'b0;
        #1;
        checks++;
        if (seg_out !== 7'h00 || dig_sel !== 8'h00 || fs !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got seg=%h dig=%h fs=%b exp 00 00 0",
                     seg_out, dig_sel, fs);
        end
        checks++;
        if (seg_out1 !== 7'h7F || dig_sel1 !== 8'hFF) begin
            errors++;
            $display("FAIL reset_pol got seg=%h dig=%h exp 7f ff",
                     seg_out1, dig_sel1);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b0;
        for (int i = 0; i < 8; i++) s[i] = 7'(i + 1);
        apply_reset();
        for (int i = 0; i < 3; i++) cyc();
    endtask

    task automatic test_walk();
        logic [7:0] ed;
        logic [6:0] es;
        fs_cnt = 0;
        en = 1'b1;
        for (int i = 0; i < 34; i++) begin
            cyc();
            if (i < 32) begin
                ed = ((i % 4) == 0) ? 8'h00 : (8'h01 << (i / 4));
                es = (i == 0) ? 7'h00 : 7'(i / 4 + 1);
                checks++;
                if (dig_sel !== ed || seg_out !== es) begin
                    errors++;
                    $display("FAIL walk%0d got seg=%h dig=%h exp seg=%h dig=%h",
                             i, seg_out, dig_sel, es, ed);
                end
            end
            if (i == 30) begin
                checks++;
                if (fs_cnt != 1) begin
                    errors++;
                    $display("FAIL first_frame_pulses got %0d exp 1", fs_cnt);
                end
            end
        end
    endtask

    task automatic test_midframe();
        for (int k = 0; k < 64 && m_idx != 1; k++) cyc();
        s[2] = 7'h3F;
        for (int k = 0; k < 64 && !(m_idx == 2 && m_cnt == 2); k++) cyc();
        cyc();
        checks++;
        if (seg_out !== 7'h03 || dig_sel !== 8'h04) begin
            errors++;
            $display("FAIL torn_frame got seg=%h dig=%h exp 03 04",
                     seg_out, dig_sel);
        end
        for (int k = 0; k < 64 && !(m_idx == 2 && m_cnt == 2); k++) cyc();
        cyc();
        checks++;
        if (seg_out !== 7'h3F || dig_sel !== 8'h04) begin
            errors++;
            $display("FAIL next_frame got seg=%h dig=%h exp 3f 04",
                     seg_out, dig_sel);
        end
    endtask

    task automatic test_en_hold();
        int fs_before;
        for (int k = 0; k < 64 && !(m_idx == 5 && m_cnt == 2); k++) cyc();
        checks++;
        if (!(m_idx == 5 && m_cnt == 2)) begin
            errors++;
            $display("FAIL hold_reach got idx=%0d cnt=%0d exp 5 2", m_idx, m_cnt);
        end
        fs_before = fs_cnt;
        en = 1'b0;
        for (int k = 0; k < 10; k++) cyc();
        checks++;
        if (fs_cnt != fs_before || dig_sel !== 8'h00) begin
            errors++;
            $display("FAIL hold_off got pulses=%0d dig=%h exp %0d 00",
                     fs_cnt, dig_sel, fs_before);
        end
        en = 1'b1;
        cyc();
        cyc();
        checks++;
        if (dig_sel !== 8'h20 || seg_out !== 7'h06) begin
            errors++;
            $display("FAIL resume got seg=%h dig=%h exp 06 20", seg_out, dig_sel);
        end
        cyc();
        checks++;
        if (dig_sel !== 8'h00 || seg_out !== 7'h07) begin
            errors++;
            $display("FAIL resume_next got seg=%h dig=%h exp 07 00",
                     seg_out, dig_sel);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 64 && m_idx != 6; k++) cyc();
        #2;
        apply_reset();
        fs_cnt = 0;
        cyc();
        cyc();
        checks++;
        if (fs_cnt != 1 || dig_sel !== 8'h01 || seg_out !== 7'h01) begin
            errors++;
            $display("FAIL restart got pulses=%0d seg=%h dig=%h exp 1 01 01",
                     fs_cnt, seg_out, dig_sel);
        end
    endtask

    task automatic test_wrap_first();
        en = 1'b0;
        apply_reset();
        for (int k = 0; k < 5; k++) cyc();
        fs_cnt = 0;
        en = 1'b1;
        for (int k = 0; k < 31; k++) cyc();
        checks++;
        if (fs_cnt != 1) begin
            errors++;
            $display("FAIL single_load got %0d exp 1", fs_cnt);
        end
        cyc();
        checks++;
        if (fs_cnt != 2) begin
            errors++;
            $display("FAIL wrap_load got %0d exp 2", fs_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fs_cnt = 0;
        rst    = 1'b1;
        en     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s[i] = 7'h00;
            p[i] = (i == 0) ? 7'h01 : 7'h00;
        end
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_walk();
        test_midframe();
        test_en_hold();
        test_reset_mid();
        test_wrap_first();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
